// File: rtl/int_claim_pkg.sv
// ============================================================================
// Module   : int_claim_pkg
// Brief    : Shared constants, gateway state encoding and round-robin search
//            for the interrupt claim arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package int_claim_pkg;

    localparam int ID_NONE   = 0;
    localparam int c_MAX_SRC = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PEND   = 2'd1,
        FLIGHT = 2'd2
    } gw_state_e;

    // Returns the first set ID after 'last', wrapping from n_src to 1; ID_NONE if none.
    function automatic int rr_next(input logic [c_MAX_SRC-1:0] elig,
                                   input int n_src,
                                   input int last);
        int pick;
        int id;
        pick = ID_NONE;
        for (int k = 1; k <= c_MAX_SRC; k++) begin
            id = ((last + k - 1) % n_src) + 1;
            if ((k <= n_src) && (pick == ID_NONE) && elig[id-1]) begin
                pick = id;
            end
        end
        return pick;
    endfunction

endpackage

`default_nettype wire

// File: rtl/int_gateway.sv
// ============================================================================
// Module   : int_gateway
// Brief    : Per-source pending/in-flight gateway. Optional two-flop input
//            synchronizer when INT_CLAIM_SYNC_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module int_gateway
    import int_claim_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic i_int,
    input  logic i_grant,
    input  logic i_complete,
    output logic o_pending,
    output logic o_inflight
);

    gw_state_e r_state;
    gw_state_e w_state_nxt;
    logic      w_int;

`ifdef INT_CLAIM_SYNC_EN
    logic [1:0] r_sync;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], i_int};
        end
    end

    assign w_int = r_sync[1];
`else
    assign w_int = i_int;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The level input is only observed in IDLE, so a held line cannot re-pend while in flight.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_int)      w_state_nxt = PEND;
            PEND:    if (i_grant)    w_state_nxt = FLIGHT;
            FLIGHT:  if (i_complete) w_state_nxt = IDLE;
            default:                 w_state_nxt = IDLE;
        endcase
    end

    assign o_pending  = (r_state == PEND);
    assign o_inflight = (r_state == FLIGHT);

endmodule

`default_nettype wire

// File: rtl/int_claim_arbiter.sv
// ============================================================================
// Module   : int_claim_arbiter
// Brief    : Interrupt gateway array with enable mask, round-robin claim
//            arbitration and completion. Optional INT_CLAIM_SYNC_EN adds
//            input synchronizers inside each gateway.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module int_claim_arbiter
    import int_claim_pkg::*;
#(
    parameter int N_SRC = 5,
    parameter int ID_W  = $clog2(N_SRC + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [N_SRC-1:0]  int_in,
    input  logic              en_wr_valid,
    input  logic [N_SRC-1:0]  en_wr_data,
    output logic              irq_out,
    input  logic              claim_req,
    output logic              claim_resp_valid,
    output logic [ID_W-1:0]   claim_resp_id,
    input  logic              complete_valid,
    input  logic [ID_W-1:0]   complete_id,
    output logic [N_SRC-1:0]  pending_out,
    output logic [N_SRC-1:0]  inflight_out
);

    logic [N_SRC-1:0]     w_pending;
    logic [N_SRC-1:0]     w_inflight;
    logic [N_SRC-1:0]     w_eligible;
    logic [N_SRC-1:0]     w_grant_vec;
    logic [N_SRC-1:0]     w_complete_vec;
    logic [c_MAX_SRC-1:0] w_elig_ext;
    logic [ID_W-1:0]      w_grant_id;

    logic [N_SRC-1:0]     r_enable;
    logic [ID_W-1:0]      r_last_grant;
    logic                 r_resp_valid;
    logic [ID_W-1:0]      r_resp_id;

    assign w_eligible = w_pending & r_enable;
    assign w_elig_ext = c_MAX_SRC'(w_eligible);

    // Arbitration sees only registered state, so same-cycle completes, enable writes
    // and new requests affect the next claim, not this one.
    assign w_grant_id = claim_req
                      ? ID_W'(rr_next(w_elig_ext, N_SRC, int'(r_last_grant)))
                      : ID_W'(ID_NONE);

    for (genvar i = 0; i < N_SRC; i++) begin : g_src
        assign w_grant_vec[i]    = (w_grant_id == ID_W'(i + 1));
        assign w_complete_vec[i] = complete_valid && (complete_id == ID_W'(i + 1));

        int_gateway u_gateway (
            .clock      (clock),
            .reset      (reset),
            .i_int      (int_in[i]),
            .i_grant    (w_grant_vec[i]),
            .i_complete (w_complete_vec[i]),
            .o_pending  (w_pending[i]),
            .o_inflight (w_inflight[i])
        );
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_enable     <= '0;
            r_last_grant <= ID_W'(N_SRC);
            r_resp_valid <= 1'b0;
            r_resp_id    <= '0;
        end else begin
            if (en_wr_valid) begin
                r_enable <= en_wr_data;
            end
            r_resp_valid <= claim_req;
            r_resp_id    <= w_grant_id;
            if (w_grant_id != ID_W'(ID_NONE)) begin
                r_last_grant <= w_grant_id;
            end
        end
    end

    assign irq_out          = |w_eligible;
    assign claim_resp_valid = r_resp_valid;
    assign claim_resp_id    = r_resp_id;
    assign pending_out      = w_pending;
    assign inflight_out     = w_inflight;

endmodule

`default_nettype wire

// File: tb/tb_int_claim_arbiter.sv
// ============================================================================
// Module   : tb_int_claim_arbiter
// Brief    : Directed self-checking bench for int_claim_arbiter (latencies
//            adapt when INT_CLAIM_SYNC_EN is defined).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_int_claim_arbiter;

    localparam int N_SRC = 5;
    localparam int ID_W  = 3;
`ifdef INT_CLAIM_SYNC_EN
    localparam int SYNC_EXTRA = 2;
`else
    localparam int SYNC_EXTRA = 0;
`endif

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic [N_SRC-1:0] int_in = '0;
    logic             en_wr_valid = 1'b0;
    logic [N_SRC-1:0] en_wr_data = '0;
    logic             irq_out;
    logic             claim_req = 1'b0;
    logic             claim_resp_valid;
    logic [ID_W-1:0]  claim_resp_id;
    logic             complete_valid = 1'b0;
    logic [ID_W-1:0]  complete_id = '0;
    logic [N_SRC-1:0] pending_out;
    logic [N_SRC-1:0] inflight_out;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    int_claim_arbiter #(.N_SRC(N_SRC), .ID_W(ID_W)) dut (
        .clock            (clock),
        .reset            (reset),
        .int_in           (int_in),
        .en_wr_valid      (en_wr_valid),
        .en_wr_data       (en_wr_data),
        .irq_out          (irq_out),
        .claim_req        (claim_req),
        .claim_resp_valid (claim_resp_valid),
        .claim_resp_id    (claim_resp_id),
        .complete_valid   (complete_valid),
        .complete_id      (complete_id),
        .pending_out      (pending_out),
        .inflight_out     (inflight_out)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        repeat (SYNC_EXTRA) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic write_enable(input logic [N_SRC-1:0] mask);
        en_wr_valid = 1'b1;
        en_wr_data  = mask;
        tick();
        en_wr_valid = 1'b0;
    endtask

    task automatic pulse_int(input logic [N_SRC-1:0] bits);
        int_in = bits;
        tick();
        int_in = '0;
        settle();
    endtask

    task automatic complete(input logic [ID_W-1:0] id);
        complete_valid = 1'b1;
        complete_id    = id;
        tick();
        complete_valid = 1'b0;
        complete_id    = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        reset = 1'b0;
        check("rst_irq", irq_out, 0);
        check("rst_valid", claim_resp_valid, 0);
        check("rst_id", claim_resp_id, 0);
        check("rst_pend", pending_out, 0);
        check("rst_infl", inflight_out, 0);

        // Single source: pulse ID 3, claim it
        write_enable(5'b11111);
        pulse_int(5'b00100);
        check("s1_irq", irq_out, 1);
        check("s1_pend", pending_out, 5'b00100);
        claim_req = 1'b1;
        tick();
        claim_req = 1'b0;
        check("s1_valid", claim_resp_valid, 1);
        check("s1_id", claim_resp_id, 3);
        check("s1_irq_off", irq_out, 0);
        check("s1_infl", inflight_out, 5'b00100);
        check("s1_pend_clr", pending_out, 0);
        tick();
        check("s1_valid_drop", claim_resp_valid, 0);
        complete(3'd3);
        check("s1_done", inflight_out, 0);

        // Five back-to-back claims after reset, then an empty claim
        do_reset();
        write_enable(5'b11111);
        pulse_int(5'b11111);
        check("s2_pend", pending_out, 5'b11111);
        claim_req = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            check("s2_valid", claim_resp_valid, 1);
            check("s2_id", claim_resp_id, k);
        end
        check("s2_irq_off", irq_out, 0);
        tick();
        claim_req = 1'b0;
        check("s2_empty_valid", claim_resp_valid, 1);
        check("s2_empty_id", claim_resp_id, 0);
        check("s2_empty_infl", inflight_out, 5'b11111);
        check("s2_empty_pend", pending_out, 0);

        // Held level on in-flight ID 2 re-pends one cycle after its complete
        int_in = 5'b00010;
        tick();
        tick();
        check("s3_ignored", pending_out, 0);
        complete(3'd2);
        check("s3_infl", inflight_out, 5'b11101);
        check("s3_pend_early", pending_out, 0);
        tick();
        check("s3_repend", pending_out, 5'b00010);
        check("s3_irq", irq_out, 1);
        int_in = '0;
        claim_req = 1'b1;
        tick();
        claim_req = 1'b0;
        check("s3_id", claim_resp_id, 2);
        check("s3_infl_all", inflight_out, 5'b11111);

        // Out-of-range and zero completes are ignored
        complete(3'd7);
        check("s4_cmp7", inflight_out, 5'b11111);
        complete(3'd0);
        check("s4_cmp0", inflight_out, 5'b11111);
        complete(3'd1);
        complete(3'd5);
        check("s4_infl", inflight_out, 5'b01110);

        // Claim and complete in the same cycle
        pulse_int(5'b00001);
        check("s4_pend1", pending_out, 5'b00001);
        claim_req = 1'b1;
        complete_valid = 1'b1;
        complete_id = 3'd4;
        tick();
        claim_req = 1'b0;
        complete_valid = 1'b0;
        check("s4_cc_id", claim_resp_id, 1);
        check("s4_cc_infl", inflight_out, 5'b00111);
        pulse_int(5'b10000);
        claim_req = 1'b1;
        complete_valid = 1'b1;
        complete_id = 3'd3;
        tick();
        claim_req = 1'b0;
        complete_valid = 1'b0;
        check("s4_cc2_id", claim_resp_id, 5);
        check("s4_cc2_infl", inflight_out, 5'b10011);

        // Enable masking keeps P; re-enable raises irq next cycle
        complete(3'd1);
        write_enable(5'b00000);
        pulse_int(5'b00001);
        check("s5_irq_masked", irq_out, 0);
        check("s5_pend_kept", pending_out, 5'b00001);
        write_enable(5'b00001);
        check("s5_irq_on", irq_out, 1);
        claim_req = 1'b1;
        en_wr_valid = 1'b1;
        en_wr_data = 5'b00000;
        tick();
        claim_req = 1'b0;
        en_wr_valid = 1'b0;
        check("s5_old_en_id", claim_resp_id, 1);
        check("s5_irq_off", irq_out, 0);
        check("s5_infl", inflight_out, 5'b10011);

        // Reset asserted while a response is outstanding
        write_enable(5'b11111);
        pulse_int(5'b00100);
        claim_req = 1'b1;
        tick();
        check("s6_pre_valid", claim_resp_valid, 1);
        check("s6_pre_id", claim_resp_id, 3);
        reset = 1'b1;
        #1;
        check("s6_valid", claim_resp_valid, 0);
        check("s6_id", claim_resp_id, 0);
        check("s6_pend", pending_out, 0);
        check("s6_infl", inflight_out, 0);
        check("s6_irq", irq_out, 0);
        claim_req = 1'b0;
        tick();
        reset = 1'b0;

        // Interrupt-to-irq latency and last_grant reset value
        write_enable(5'b11111);
        int_in = 5'b00001;
        tick();
        int_in = '0;
        check("s7_lat1", irq_out, 32'(SYNC_EXTRA == 0));
        tick();
        check("s7_lat2", irq_out, 32'(SYNC_EXTRA == 0));
        tick();
        check("s7_lat3", irq_out, 1);
        claim_req = 1'b1;
        tick();
        claim_req = 1'b0;
        check("s7_id", claim_resp_id, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
